// File: rtl/log_ctrl_pkg.sv
// Shared definitions for the ram_save capture/dump sequencer: state codes and
// the default RAM read latency.
package log_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_FULL    = 3'd3,
    ST_RD      = 3'd4,
    ST_WAIT    = 3'd5,
    ST_OUT     = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  localparam int RD_LATENCY_DEF = 3;

  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/log_ctrl_dump.sv
// Readout datapath: RAM address counter, read-latency counter and the stream
// output register with its valid/ready handshake.
module log_ctrl_dump
  import log_ctrl_pkg::*;
#(
  parameter int NB_ADDR    = 11,
  parameter int NB_DATA    = 16,
  parameter int RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               rd_i,
  input  logic               wait_i,
  input  logic               ready_i,
  input  logic [NB_DATA-1:0] ram_data_i,
  output logic [NB_ADDR-1:0] ram_addr_o,
  output logic [NB_DATA-1:0] data_o,
  output logic               valid_o,
  output logic               cnt_zero_o,
  output logic               accept_o,
  output logic               last_o
);

  localparam int LAT_W = cnt_width(RD_LATENCY);
  localparam logic [LAT_W-1:0]   LAT_LOAD  = LAT_W'(RD_LATENCY - 1);
  localparam logic [NB_ADDR-1:0] ADDR_LAST = '1;

  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               valid_q, valid_d;

  assign cnt_zero_o = (cnt_q == '0);
  assign accept_o   = valid_q & ready_i;
  assign last_o     = accept_o & (addr_q == ADDR_LAST);
  assign ram_addr_o = addr_q;
  assign data_o     = data_q;
  assign valid_o    = valid_q;

  always_comb begin
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (abort_i) begin
      addr_d  = '0;
      valid_d = 1'b0;
    end else begin
      if (start_i) begin
        addr_d = '0;
      end else if (accept_o && !last_o) begin
        addr_d = addr_q + NB_ADDR'(1);
      end else begin
        addr_d = addr_q;
      end

      if (rd_i) begin
        cnt_d = LAT_LOAD;
      end else if (wait_i && !cnt_zero_o) begin
        cnt_d = cnt_q - LAT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end

      // Word is captured on the cycle the latency count has run out
      if (wait_i && cnt_zero_o) begin
        valid_d = 1'b1;
        data_d  = ram_data_i;
      end else if (accept_o) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/log_ram_ctrl.sv
// Capture/dump sequencer for ram_save. Optional capture timeout is enabled by
// defining LOG_CTRL_TIMEOUT_EN.
module log_ram_ctrl
  import log_ctrl_pkg::*;
#(
  parameter int NB_ADDR    = 11,
  parameter int NB_DATA    = 16,
  parameter int RD_LATENCY = RD_LATENCY_DEF
`ifdef LOG_CTRL_TIMEOUT_EN
  , parameter int NB_TIMEOUT = 24
`endif
) (
  input  logic               clock,
  input  logic               cpu_reset_n,
  input  logic               i_start,
  input  logic               i_dump,
  input  logic               i_abort,
  input  logic               i_full_from_ram,
  input  logic [NB_DATA-1:0] i_data_from_ram,
  output logic               o_log_ram_run,
  output logic [NB_ADDR-1:0] o_ram_read_addr,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2:0]         o_state,
  output logic               o_done,
  output logic               o_timeout
);

  state_t state_q;
  logic   run_q;
  logic   done_q;
  logic   dump_start_s;
  logic   cnt_zero_s;
  logic   accept_s;
  logic   last_s;

`ifdef LOG_CTRL_TIMEOUT_EN
  localparam logic [NB_TIMEOUT-1:0] TMO_PRE = {{(NB_TIMEOUT-1){1'b1}}, 1'b0};
  logic [NB_TIMEOUT-1:0] tmo_q;
  logic                  timeout_q;
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  // i_start outranks i_dump in FULL, and i_abort outranks both
  assign dump_start_s = (state_q == ST_FULL) & i_dump & ~i_start & ~i_abort;

  log_ctrl_dump #(
    .NB_ADDR    (NB_ADDR),
    .NB_DATA    (NB_DATA),
    .RD_LATENCY (RD_LATENCY)
  ) u_dump (
    .clk_i      (clock),
    .rst_ni     (cpu_reset_n),
    .start_i    (dump_start_s),
    .abort_i    (i_abort),
    .rd_i       (state_q == ST_RD),
    .wait_i     (state_q == ST_WAIT),
    .ready_i    (i_ready),
    .ram_data_i (i_data_from_ram),
    .ram_addr_o (o_ram_read_addr),
    .data_o     (o_data),
    .valid_o    (o_valid),
    .cnt_zero_o (cnt_zero_s),
    .accept_o   (accept_s),
    .last_o     (last_s)
  );

  // run stays high from CAPTURE through the dump so ram_save keeps the RAM frozen
  always_ff @(posedge clock or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state_q   <= ST_IDLE;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef LOG_CTRL_TIMEOUT_EN
      tmo_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (i_abort) begin
        state_q <= ST_IDLE;
        run_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (i_start) begin
              state_q   <= ST_ARM;
`ifdef LOG_CTRL_TIMEOUT_EN
              timeout_q <= 1'b0;
`endif
            end
          end
          ST_ARM: begin
            state_q <= ST_CAPTURE;
            run_q   <= 1'b1;
`ifdef LOG_CTRL_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
          ST_CAPTURE: begin
            if (i_full_from_ram) begin
              state_q <= ST_FULL;
            end
`ifdef LOG_CTRL_TIMEOUT_EN
            else begin
              tmo_q <= tmo_q + NB_TIMEOUT'(1);
              if (tmo_q == TMO_PRE) begin
                timeout_q <= 1'b1;
                state_q   <= ST_IDLE;
                run_q     <= 1'b0;
              end
            end
`endif
          end
          ST_FULL: begin
            if (i_start) begin
              state_q   <= ST_ARM;
              run_q     <= 1'b0;
`ifdef LOG_CTRL_TIMEOUT_EN
              timeout_q <= 1'b0;
`endif
            end else if (i_dump) begin
              state_q <= ST_RD;
            end
          end
          ST_RD: begin
            state_q <= ST_WAIT;
          end
          ST_WAIT: begin
            if (cnt_zero_s) begin
              state_q <= ST_OUT;
            end
          end
          ST_OUT: begin
            if (last_s) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              run_q   <= 1'b0;
            end else if (accept_s) begin
              state_q <= ST_RD;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_state       = state_q;
  assign o_log_ram_run = run_q;
  assign o_done        = done_q;

endmodule
